fixed_exp_lut_scheduler: RTL and testbench
==========================================

Name: fixed_exp_lut_scheduler

Overview:
- Shared e^(-x) engine for N_REQ requesters; computes the exponential by round-robin arbitration plus sequenced LUT and multiply steps.
- Drives the 3-bit address of an external fractional exp LUT. The LUT is a combinational 8-entry table holding e^(-addr/8) in Q1.16 (17 bits).
- The integer part of x is applied by repeated multiplication with the constant e^-1 on an internal multiplier.
- Sits between softmax/activation producers and a single LUT instance, so the LUT is not duplicated per lane.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- IN_WIDTH, 8, unsigned input width; 3 fractional bits, IN_WIDTH-3 integer bits.
- SAT_INT, 12, integer-part threshold at or above which the result is forced to 0.
- E_INV, 24109, Q1.16 value of e^-1 (17 bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in_0  in  N_REQ*IN_WIDTH  packed x values; requester i occupies bits [i*IN_WIDTH +: IN_WIDTH]
- data_in_0_valid  in  N_REQ  per-requester valid
- data_in_0_ready  out  N_REQ  per-requester ready (one-hot or zero)
- lut_address  out  3  address to the fractional LUT
- lut_data  in  17  LUT read data, combinational from lut_address
- data_out_0  out  17  result e^(-x), Q1.16
- data_out_0_id  out  $clog2(N_REQ)  index of the requester that owns the result
- data_out_0_valid  out  1  result valid
- data_out_0_ready  in  1  downstream ready

Behaviour:
- Reset values:
  - data_in_0_ready=0, data_out_0_valid=0, data_out_0=0, data_out_0_id=0, lut_address=0.
  - RR pointer=0, FSM enters IDLE.
  - Reset mid-operation aborts the job; no result is emitted.
- FSM states: IDLE, LOOKUP, MUL, DONE.
- IDLE:
  - Grant goes to the first valid requester at or after the pointer, wrapping.
  - data_in_0_ready[grant]=1 combinationally in IDLE only; all other ready bits are 0.
  - On handshake, latch frac=x[2:0], int=x[IN_WIDTH-1:3], id=grant; pointer <= grant+1 (mod N_REQ); go to LOOKUP.
  - No valid requester: stay in IDLE, pointer unchanged.
- LOOKUP (1 cycle):
  - lut_address=frac; acc <= lut_data.
  - If int>=SAT_INT: result=0, go to DONE.
  - Else if int==0: go to DONE.
  - Else: cnt <= int, go to MUL.
- MUL (one multiply per cycle):
  - acc <= (acc*E_INV)>>16. The 34-bit product is truncated with no rounding; the result always fits in 17 bits.
  - cnt decrements each cycle; go to DONE after the cycle in which cnt reaches 0.
- DONE:
  - data_out_0_valid=1; data_out_0 and data_out_0_id stay stable until data_out_0_ready=1.
  - On handshake, return to IDLE next cycle. No new accept occurs in the handshake cycle.
- Latency, with accept in cycle T:
  - valid asserts in cycle T+2+int when int<SAT_INT.
  - valid asserts in cycle T+2 when saturated.
- Throughput: at most one job per int+3 cycles (no backpressure).
- lut_address holds its last value outside LOOKUP.
- The arbiter is work-conserving; a requester cannot be granted twice while another valid requester waits.
- A requester dropping valid while not granted is legal.

Test Plan:
- req0 x=0x00, ready held 1:
  - lut_address=0 in LOOKUP.
  - data_out_0=0x10000, id=0, valid exactly 2 cycles after accept.
- req1 x=0x08 (1.0):
  - one MUL cycle; data_out_0=24109, id=1, valid at T+3.
- req2 x=0x10 (2.0):
  - two MUL cycles; data_out_0=8869, valid at T+4.
- req3 x=0x04 (0.5):
  - data_out_0 equals lut_data at address 4, passed through unmodified, valid at T+2.
- Saturation:
  - x=0x60 (12.0) -> data_out_0=0, valid at T+2, no MUL cycles.
  - x=0xFF -> data_out_0=0, valid at T+2, no MUL cycles.
- All 4 requesters valid with x=0 continuously, data_out_0_ready=1:
  - grants occur in order 0,1,2,3,0 with one-cycle ready pulses.
  - ids out occur in the same order.
  - 3 cycles between successive accepts.
- Backpressure: data_out_0_ready=0 for 5 cycles in DONE:
  - result and id are stable.
  - all data_in_0_ready bits are 0.
  - accept resumes the cycle after the handshake.
- Reset in mid-MUL (x=0x28):
  - rst=1 for one cycle -> next cycle valid=0, ready=0.
  - the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/fixed_exp_lut_scheduler.sv
// Shared e^(-x) engine: round-robin arbitration across requesters, one fractional
// LUT lookup, then one multiply by e^-1 per integer unit of x.
module fixed_exp_lut_scheduler #(
    parameter int N_REQ    = 4,
    parameter int IN_WIDTH = 8,
    parameter int SAT_INT  = 12,
    parameter int E_INV    = 24109
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*IN_WIDTH-1:0]   data_in_0,
    input  logic [N_REQ-1:0]            data_in_0_valid,
    output logic [N_REQ-1:0]            data_in_0_ready,
    output logic [2:0]                  lut_address,
    input  logic [16:0]                 lut_data,
    output logic [16:0]                 data_out_0,
    output logic [$clog2(N_REQ)-1:0]    data_out_0_id,
    output logic                        data_out_0_valid,
    input  logic                        data_out_0_ready
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int INT_W = IN_WIDTH - 3;
    localparam logic [16:0] E_INV_C = 17'(E_INV);

    typedef enum logic [1:0] {IDLE, LOOKUP, MUL, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     id_reg;
    logic [ID_W-1:0]     grant;
    logic                grant_valid;
    logic [2:0]          lut_addr_reg;
    logic [INT_W-1:0]    int_reg;
    logic [INT_W-1:0]    cnt_reg;
    logic [16:0]         acc_reg;
    logic [33:0]         product;
    logic                saturated;
    logic [IN_WIDTH-1:0] x_lane [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign x_lane[gi] = data_in_0[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    // Scan from the highest rotation down so the lowest offset from the pointer wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (data_in_0_valid[(int'(ptr_reg) + k) % N_REQ]) begin
                grant       = ID_W'((int'(ptr_reg) + k) % N_REQ);
                grant_valid = 1'b1;
            end
        end
    end

    assign saturated = (int'(int_reg) >= SAT_INT);
    assign product   = {17'b0, acc_reg} * {17'b0, E_INV_C};

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        data_in_0_ready  = '0;
        data_out_0_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    data_in_0_ready[grant] = 1'b1;
                    state_next             = LOOKUP;
                end
            end
            LOOKUP: begin
                if (saturated || int_reg == '0) state_next = DONE;
                else                            state_next = MUL;
            end
            MUL: begin
                if (cnt_reg == INT_W'(1)) state_next = DONE;
            end
            DONE: begin
                data_out_0_valid = 1'b1;
                if (data_out_0_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            id_reg       <= '0;
            lut_addr_reg <= '0;
            int_reg      <= '0;
            cnt_reg      <= '0;
            acc_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        lut_addr_reg <= x_lane[grant][2:0];
                        int_reg      <= x_lane[grant][IN_WIDTH-1:3];
                        id_reg       <= grant;
                        ptr_reg      <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                LOOKUP: begin
                    acc_reg <= saturated ? 17'd0 : lut_data;
                    cnt_reg <= int_reg;
                end
                MUL: begin
                    // Truncating multiply; e^-1 < 1 keeps the result within 17 bits.
                    acc_reg <= product[32:16];
                    cnt_reg <= cnt_reg - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lut_address   = lut_addr_reg;
    assign data_out_0    = acc_reg;
    assign data_out_0_id = id_reg;

endmodule

// File: tb/tb_fixed_exp_lut_scheduler.sv
// Directed bench for fixed_exp_lut_scheduler: vector table of single jobs plus
// backpressure, mid-job reset and round-robin sequences.
module tb_fixed_exp_lut_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] data_in_0;
    logic [N-1:0]  data_in_0_valid;
    logic [N-1:0]  data_in_0_ready;
    logic [2:0]    lut_address;
    logic [16:0]   lut_data;
    logic [16:0]   data_out_0;
    logic [1:0]    data_out_0_id;
    logic          data_out_0_valid;
    logic          data_out_0_ready;

    int checks = 0;
    int errors = 0;

    fixed_exp_lut_scheduler #(
        .N_REQ(N), .IN_WIDTH(W), .SAT_INT(12), .E_INV(24109)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in_0(data_in_0), .data_in_0_valid(data_in_0_valid),
        .data_in_0_ready(data_in_0_ready),
        .lut_address(lut_address), .lut_data(lut_data),
        .data_out_0(data_out_0), .data_out_0_id(data_out_0_id),
        .data_out_0_valid(data_out_0_valid), .data_out_0_ready(data_out_0_ready)
    );

    always #5 clk = ~clk;

    // e^(-a/8) in Q1.16
    function automatic logic [16:0] lut_val(input logic [2:0] a);
        case (a)
            3'd0: return 17'd65536;
            3'd1: return 17'd57835;
            3'd2: return 17'd51039;
            3'd3: return 17'd45042;
            3'd4: return 17'd39749;
            3'd5: return 17'd35078;
            3'd6: return 17'd30957;
            default: return 17'd27319;
        endcase
    endfunction

    assign lut_data = lut_val(lut_address);

    typedef struct {
        int          req;
        logic [7:0]  x;
        logic [16:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int req, input logic [7:0] x, input logic [16:0] res, input int lat_exp);
        int t;
        int lat;
        data_out_0_ready = 1'b1;
        data_in_0[req*W +: W] = x;
        data_in_0_valid = '0;
        data_in_0_valid[req] = 1'b1;
        #1;
        t = 0;
        while (!data_in_0_ready[req] && t < 50) begin
            tick();
            t++;
        end
        check("job_grant", 64'(data_in_0_ready[req]), 64'd1);
        tick();
        data_in_0_valid = '0;
        #1;
        check("job_lut_addr", 64'(lut_address), 64'(x[2:0]));
        lat = 1;
        while (!data_out_0_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("job_valid", 64'(data_out_0_valid), 64'd1);
        check("job_data", 64'(data_out_0), 64'(res));
        check("job_id", 64'(data_out_0_id), 64'(req));
        check("job_latency", 64'(lat), 64'(lat_exp));
        $display("job req=%0d x=0x%02h out=%0d id=%0d latency=%0d", req, x, data_out_0, data_out_0_id, lat);
        tick();
    endtask

    initial begin
        int t;
        int g_cnt;
        int i_cnt;
        int last_t;
        int cyc;
        int g;

        vecs[0] = '{0, 8'h00, 17'd65536, 2};
        vecs[1] = '{1, 8'h08, 17'd24109, 3};
        vecs[2] = '{2, 8'h10, 17'd8869,  4};
        vecs[3] = '{3, 8'h04, 17'd39749, 2};
        vecs[4] = '{0, 8'h60, 17'd0,     2};
        vecs[5] = '{1, 8'hFF, 17'd0,     2};
        vecs[6] = '{2, 8'h0B, 17'd16569, 3};
        vecs[7] = '{3, 8'h18, 17'd3262,  5};

        rst = 1'b1;
        data_in_0 = '0;
        data_in_0_valid = '0;
        data_out_0_ready = 1'b1;
        repeat (3) tick();
        check("rst_ready", 64'(data_in_0_ready), 64'd0);
        check("rst_valid", 64'(data_out_0_valid), 64'd0);
        check("rst_data", 64'(data_out_0), 64'd0);
        check("rst_id", 64'(data_out_0_id), 64'd0);
        check("rst_lut_addr", 64'(lut_address), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].req, vecs[i].x, vecs[i].res, vecs[i].lat);
        end

        // Backpressure: hold result for 5 cycles while requester 2 waits.
        data_out_0_ready = 1'b0;
        data_in_0[1*W +: W] = 8'h08;
        data_in_0_valid = 4'b0010;
        #1;
        t = 0;
        while (!data_in_0_ready[1] && t < 50) begin tick(); t++; end
        check("bp_grant", 64'(data_in_0_ready), 64'b0010);
        tick();
        data_in_0_valid = 4'b0100;
        data_in_0[2*W +: W] = 8'h00;
        #1;
        t = 0;
        while (!data_out_0_valid && t < 50) begin tick(); t++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(data_out_0_valid), 64'd1);
            check("bp_data", 64'(data_out_0), 64'd24109);
            check("bp_id", 64'(data_out_0_id), 64'd1);
            check("bp_ready_low", 64'(data_in_0_ready), 64'd0);
            tick();
        end
        data_out_0_ready = 1'b1;
        #1;
        check("bp_handshake_no_accept", 64'(data_in_0_ready), 64'd0);
        $display("job req=1 x=0x08 out=%0d id=%0d held under backpressure", data_out_0, data_out_0_id);
        tick();
        check("bp_resume_grant", 64'(data_in_0_ready), 64'b0100);
        tick();
        data_in_0_valid = '0;
        #1;
        t = 0;
        while (!data_out_0_valid && t < 50) begin tick(); t++; end
        check("bp_next_data", 64'(data_out_0), 64'd65536);
        check("bp_next_id", 64'(data_out_0_id), 64'd2);
        $display("job req=2 x=0x00 out=%0d id=%0d after backpressure", data_out_0, data_out_0_id);
        tick();

        // Reset in the middle of a multi-cycle job; pointer moves to 1 beforehand.
        data_in_0[0 +: W] = 8'h28;
        data_in_0_valid = 4'b0001;
        #1;
        t = 0;
        while (!data_in_0_ready[0] && t < 50) begin tick(); t++; end
        tick();
        data_in_0_valid = '0;
        tick();
        tick();
        check("mid_mul_valid", 64'(data_out_0_valid), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 64'(data_out_0_valid), 64'd0);
        check("mid_rst_ready", 64'(data_in_0_ready), 64'd0);
        check("mid_rst_data", 64'(data_out_0), 64'd0);
        check("mid_rst_id", 64'(data_out_0_id), 64'd0);
        $display("job req=0 x=0x28 aborted by reset");

        // All requesters valid continuously with x=0.
        data_in_0 = '0;
        data_in_0_valid = 4'b1111;
        data_out_0_ready = 1'b1;
        #1;
        g_cnt = 0;
        i_cnt = 0;
        last_t = 0;
        cyc = 0;
        while ((g_cnt < 5 || i_cnt < 5) && cyc < 60) begin
            if (data_in_0_ready != '0 && g_cnt < 5) begin
                check("rr_onehot", 64'($onehot(data_in_0_ready)), 64'd1);
                g = 0;
                for (int k = 0; k < N; k++) if (data_in_0_ready[k]) g = k;
                check("rr_grant_order", 64'(g), 64'(g_cnt % N));
                if (g_cnt > 0) check("rr_accept_gap", 64'(cyc - last_t), 64'd3);
                $display("rr grant=%0d cycle=%0d", g, cyc);
                last_t = cyc;
                g_cnt++;
            end
            if (data_out_0_valid && i_cnt < 5) begin
                check("rr_id_order", 64'(data_out_0_id), 64'(i_cnt % N));
                check("rr_data", 64'(data_out_0), 64'd65536);
                $display("rr result id=%0d out=%0d cycle=%0d", data_out_0_id, data_out_0, cyc);
                i_cnt++;
            end
            tick();
            cyc++;
        end
        check("rr_grant_count", 64'(g_cnt), 64'd5);
        check("rr_id_count", 64'(i_cnt), 64'd5);
        data_in_0_valid = '0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
